// File: rtl/foc_pkg.sv
// Shared types, widths and Q15 helpers for the field-oriented-control datapath.
// Contents: state_t (Park sequencing FSM), widths I_W/TH_W/Q_W/ACC_W, Q15_ONE, SAT_MAX/SAT_MIN, sat16().
// Pure declarations: no latency, no flow control.
package foc_pkg;

  localparam int I_W   = 12;  // phase current width
  localparam int TH_W  = 12;  // electrical angle width, 4096 = 2*pi
  localparam int Q_W   = 16;  // Q15 operand / result width
  localparam int ACC_W = 33;  // Park accumulator width (sum of two 32-bit products)

  localparam logic signed [Q_W-1:0] Q15_ONE = 16'sd32767;
  localparam logic signed [Q_W-1:0] SAT_MAX = 16'sd32767;
  localparam logic signed [Q_W-1:0] SAT_MIN = -16'sd32767;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLARKE,
    ST_WAIT_SC,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_OUT
  } state_t;

  // Symmetric clamp: -32768 is deliberately excluded so results negate cleanly downstream.
  function automatic logic signed [Q_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 33'sd32767) begin
      return SAT_MAX;
    end else if (v < -33'sd32767) begin
      return SAT_MIN;
    end else begin
      return v[Q_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sincos_lut.sv
// Sine/cosine of a 12-bit angle from a 1024-entry quarter-wave ROM with quadrant folding.
// Ports: clk, rstn (async active-low); th[11:0] in (4096 = 2*pi); sin_q/cos_q signed Q15 out.
// Latency 2 cycles (table read, then sign/select); fully pipelined, new angle every cycle.
module sincos_lut
  import foc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [TH_W-1:0]       th,
  output logic signed [Q_W-1:0] sin_q,
  output logic signed [Q_W-1:0] cos_q
);

  localparam int  QTR = 1024;
  localparam real PI  = 3.14159265358979323846;

  // Evaluated only at elaboration to fill the ROM: round(32767*sin(2*pi*n/4096)), n in [0,1023].
  function automatic logic [Q_W-1:0] q15_sin(input int n);
    real x;
    x = 32767.0 * $sin(2.0 * PI * $itor(n) / 4096.0);
    return Q_W'($rtoi(x + 0.5));
  endfunction

  logic [Q_W-1:0] rom [QTR];

  for (genvar g = 0; g < QTR; g++) begin : g_rom
    localparam logic [Q_W-1:0] ENTRY = q15_sin(g);
    assign rom[g] = ENTRY;
  end

  logic [1:0]     quad;
  logic [9:0]     idx;
  logic [9:0]     idx_rev;
  logic [1:0]     quad_r;
  logic [Q_W-1:0] mag_fwd;  // sin of the in-quadrant fraction
  logic [Q_W-1:0] mag_rev;  // cos of the in-quadrant fraction

  assign quad    = th[TH_W-1 -: 2];
  assign idx     = th[9:0];
  assign idx_rev = 10'd0 - idx;  // 1024-idx; idx=0 needs sin(pi/2), which is outside the table

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quad_r  <= 2'd0;
      mag_fwd <= '0;
      mag_rev <= '0;
    end else begin
      quad_r  <= quad;
      mag_fwd <= rom[idx];
      mag_rev <= (idx == 10'd0) ? $unsigned(Q15_ONE) : rom[idx_rev];
    end
  end

  // Magnitudes never exceed 32767, so negation cannot overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      case (quad_r)
        2'd0: begin
          sin_q <= $signed(mag_fwd);
          cos_q <= $signed(mag_rev);
        end
        2'd1: begin
          sin_q <= $signed(mag_rev);
          cos_q <= -$signed(mag_fwd);
        end
        2'd2: begin
          sin_q <= -$signed(mag_fwd);
          cos_q <= -$signed(mag_rev);
        end
        default: begin
          sin_q <= -$signed(mag_rev);
          cos_q <= $signed(mag_fwd);
        end
      endcase
    end
  end

endmodule

// File: rtl/clark_park_tf.sv
// Clarke + Park transform: 3-phase currents and rotor angle to Q15 id/iq, Park on one shared multiplier.
// Latency 7 cycles from the accepting edge to the o_en cycle; one sample per 8 cycles at most.
// No queuing: i_en is taken only when the FSM is idle, otherwise dropped.
// Ports: clk, rstn (async active-low); i_en, i_ia/i_ib/i_ic (signed 12 b), i_theta (12 b, 4096 = 2*pi) in;
//        o_busy, o_en (1-cycle pulse), o_id/o_iq (signed 16 b, held until next o_en) out.
module clark_park_tf
  import foc_pkg::*;
#(
  parameter logic signed [Q_W-1:0] K_INV_SQRT3  = 16'sd18919,
  parameter logic [TH_W-1:0]       THETA_OFFSET = 12'd0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic [I_W-1:0]   i_ia,
  input  logic [I_W-1:0]   i_ib,
  input  logic [I_W-1:0]   i_ic,
  input  logic [TH_W-1:0]  i_theta,
  output logic             o_busy,
  output logic             o_en,
  output logic [Q_W-1:0]   o_id,
  output logic [Q_W-1:0]   o_iq
);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [I_W-1:0]   ia_r;
  logic signed [I_W-1:0]   ib_r;
  logic signed [I_W-1:0]   ic_r;
  logic [TH_W-1:0]         th_r;
  logic signed [Q_W-1:0]   alpha;
  logic signed [Q_W-1:0]   beta;
  logic signed [Q_W-1:0]   sin_q;
  logic signed [Q_W-1:0]   cos_q;
  logic signed [Q_W-1:0]   mul_a;
  logic signed [Q_W-1:0]   mul_b;
  logic signed [2*Q_W-1:0] mul_p;
  logic signed [2*Q_W-1:0] clarke_p;
  logic signed [I_W:0]     diff;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] accd;
  logic signed [ACC_W-1:0] accq;
  logic                    accept;

  // th_r feeds the LUT continuously: it is stable from the accepting edge, so the LUT
  // output is valid two edges later, exactly when the FSM reaches M0.
  sincos_lut u_sincos (
    .clk   (clk),
    .rstn  (rstn),
    .th    (th_r),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  // The o_en cycle is already IDLE, so a sample arriving then is accepted; this keeps the
  // 8-cycle rate while o_busy still covers the o_en cycle.
  assign accept = (state == ST_IDLE) && i_en;
  assign o_busy = (state != ST_IDLE) || o_en;

  assign diff     = (I_W+1)'(ib_r) - (I_W+1)'(ic_r);
  assign clarke_p = 32'(diff) * 32'(K_INV_SQRT3);
  assign mul_p    = 32'(mul_a) * 32'(mul_b);
  assign prod_ext = ACC_W'(mul_p);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mul_a     = alpha;
    mul_b     = cos_q;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_CLARKE;
      ST_CLARKE:  state_nxt = ST_WAIT_SC;
      ST_WAIT_SC: state_nxt = ST_M0;
      ST_M0: begin
        mul_a     = alpha;
        mul_b     = cos_q;
        state_nxt = ST_M1;
      end
      ST_M1: begin
        mul_a     = beta;
        mul_b     = sin_q;
        state_nxt = ST_M2;
      end
      ST_M2: begin
        mul_a     = beta;
        mul_b     = cos_q;
        state_nxt = ST_M3;
      end
      ST_M3: begin
        mul_a     = alpha;
        mul_b     = sin_q;
        state_nxt = ST_OUT;
      end
      ST_OUT:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ia_r  <= '0;
      ib_r  <= '0;
      ic_r  <= '0;
      th_r  <= '0;
      alpha <= '0;
      beta  <= '0;
      accd  <= '0;
      accq  <= '0;
      o_en  <= 1'b0;
      o_id  <= '0;
      o_iq  <= '0;
    end else begin
      o_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ia_r <= i_ia;
            ib_r <= i_ib;
            ic_r <= i_ic;
            th_r <= i_theta + THETA_OFFSET;  // 12-bit add wraps modulo one turn
          end
        end
        ST_CLARKE: begin
          alpha <= Q_W'(ia_r);
          beta  <= Q_W'(clarke_p >>> 15);
        end
        ST_M0: accd <= prod_ext;
        ST_M1: accd <= accd + prod_ext;
        ST_M2: accq <= prod_ext;
        ST_M3: accq <= accq - prod_ext;
        ST_OUT: begin
          o_en <= 1'b1;
          o_id <= sat16(accd >>> 15);
          o_iq <= sat16(accq >>> 15);
        end
        default: ;
      endcase
    end
  end

endmodule
